// File: rtl/int2float_if.sv
// rtl/int2float_if.sv - operand/result handshake bundle for int2float_seq
// master drives operands and result acceptance; slave is the converter.
interface int2float_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] float_out;
  logic        precision_lost;

  modport master (
    output in_valid, int_in, out_ready,
    input  in_ready, out_valid, float_out, precision_lost
  );

  modport slave (
    input  in_valid, int_in, out_ready,
    output in_ready, out_valid, float_out, precision_lost
  );
endinterface

// File: rtl/int2float_seq.sv
// rtl/int2float_seq.sv - multi-cycle int32 to IEEE-754 single converter
// Optional macro INT2FLOAT_ROUND_EN selects round-to-nearest-even; default truncates.
module int2float_seq (
  input  logic         clk,
  input  logic         rst_n,
  int2float_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state_q;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [7:0]  exp_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] float_q;
  logic        plost_q;

  logic [31:0] abs_d;
  logic [22:0] mant_d;
  logic [7:0]  exp_d;
`ifdef INT2FLOAT_ROUND_EN
  logic [23:0] mant_inc;
  logic        round_up;
`endif

  // 32-bit wrap makes |0x80000000| come out as unsigned 2^31.
  always_comb begin
    abs_d  = bus.int_in[31] ? (~bus.int_in + 32'd1) : bus.int_in;
    mant_d = mag_q[30:8];
    exp_d  = exp_q;
`ifdef INT2FLOAT_ROUND_EN
    mant_inc = {1'b0, mag_q[30:8]} + 24'd1;
    round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
    if (round_up) begin
      mant_d = mant_inc[22:0];
      if (mant_inc[23]) begin
        exp_d = exp_q + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= 32'd0;
      exp_q       <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      float_q     <= 32'd0;
      plost_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q     <= bus.int_in[31];
            mag_q      <= abs_d;
            exp_q      <= 8'd158;
            in_ready_q <= 1'b0;
            if (bus.int_in == 32'd0) begin
              float_q     <= 32'd0;
              plost_q     <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (mag_q[31]) begin
            state_q <= ROUND;
          end else begin
            mag_q <= {mag_q[30:0], 1'b0};
            exp_q <= exp_q - 8'd1;
          end
        end
        ROUND: begin
          exp_q       <= exp_d;
          float_q     <= {sign_q, exp_d, mant_d};
          plost_q     <= |mag_q[7:0];
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.float_out      = float_q;
  assign bus.precision_lost = plost_q;

endmodule
